gpc_axis_tx_pad: RTL
====================

// Module: gpc_axis_tx_pad
// PURPOSE
//  Downstream of the AXI-Lite->AXI-Stream register stage, directly feeding the CMAC TX AXI-Stream port.
//  Enforces Ethernet minimum frame length: pads short frames (tkeep extended, pad bytes zeroed).
//  Also checks tkeep legality and decouples both sides with a registered, full-throughput skid buffer.
//  Exposes saturating frame / pad / error counters for status reads.
// PARAMETERS
//  AXIS_DATA_WIDTH  512                  stream data width in bits (multiple of 8)
//  AXIS_KEEP_WIDTH  AXIS_DATA_WIDTH/8    tkeep width in bits
//  MIN_FRAME_BYTES  60                   minimum frame length in bytes, excluding FCS; must be <= AXIS_KEEP_WIDTH
//  CNT_WIDTH        32                   width of each status counter
// PORTS
//  clk            in   1                 clock
//  rst_n          in   1                 asynchronous reset, active low
//  s_axis_tdata   in   AXIS_DATA_WIDTH   frame data from register stage
//  s_axis_tkeep   in   AXIS_KEEP_WIDTH   byte enables, bit i -> byte i
//  s_axis_tvalid  in   1                 input beat valid
//  s_axis_tready  out  1                 input beat accepted
//  s_axis_tlast   in   1                 last beat of frame
//  m_axis_tdata   out  AXIS_DATA_WIDTH   data to CMAC
//  m_axis_tkeep   out  AXIS_KEEP_WIDTH   byte enables to CMAC
//  m_axis_tvalid  out  1                 output beat valid
//  m_axis_tready  in   1                 CMAC ready
//  m_axis_tlast   out  1                 last beat to CMAC
//  frame_count    out  CNT_WIDTH         frames forwarded (counted on output tlast handshake)
//  pad_count      out  CNT_WIDTH         frames that were padded
//  err_count      out  CNT_WIDTH         tkeep violations detected
// BEHAVIOUR
//  Reset (rst_n=0, async): m_axis_tvalid=0, s_axis_tready=0, m_axis_tdata/tkeep/tlast=0, all counters=0,
//   skid buffer empty, FSM=ST_FIRST. In-flight beats are discarded. First clk after release: s_axis_tready=1.
//  FSM (input side, advances only on s_axis handshake):
//   ST_FIRST: current beat is first of frame. tlast=1 -> stay ST_FIRST; tlast=0 -> ST_MID.
//   ST_MID:   tlast=1 -> ST_FIRST; else stay.
//  Padding: applies only to a beat accepted in ST_FIRST with tlast=1 and popcount(tkeep) < MIN_FRAME_BYTES.
//   out tkeep = in tkeep | MIN_MASK (MIN_MASK = low MIN_FRAME_BYTES bits set).
//   out data byte i = 8'h00 where in tkeep[i]=0 and MIN_MASK[i]=1; other bytes pass unchanged.
//   pad_count +1 on acceptance of such a beat.
//   Multi-beat frames are never padded (non-last beats are full, so length >= AXIS_KEEP_WIDTH).
//  Errors (err_count +1 per offending accepted beat; beat still forwarded, unpadded beyond the above):
//   non-last beat with tkeep != all ones; any beat with tkeep == 0.
//   A tkeep==0 single-beat frame is padded to MIN_MASK (all-zero data) and is counted in both err_count and pad_count.
//  Datapath: output register plus one skid entry. Latency input handshake -> m_axis_tvalid = 1 cycle.
//   s_axis_tready is registered: equals !skid_valid. Sustains 1 beat/cycle while m_axis_tready=1.
//   m_axis_tready low: beat in flight goes to skid; tready drops next cycle. Nothing is dropped or duplicated.
//   Output beat held stable while m_axis_tvalid=1 and m_axis_tready=0 (AXIS rule).
//   When skid drains, the skid beat moves to output before any new input beat; order is strictly preserved.
//  Counters saturate at all ones. Counter updates are registered, visible the cycle after the event.
//   Simultaneous events each increment their own counter.
//  m_axis_tvalid never depends combinationally on m_axis_tready.
// TESTING
//  1) Single beat, tkeep=64'h0000_0000_FFFF_FFFF (32 B), tlast=1 -> out tkeep=64'h0FFF_FFFF_FFFF_FFFF;
//     bytes 32..59 = 0; pad_count=1; frame_count=1.
//  2) 2-beat frame, beat0 keep all ones, beat1 keep=64'hFF -> unchanged; pad_count=0; frame_count=1.
//  3) Back-to-back 100 single-beat 64 B frames, m_axis_tready=1 -> 1 beat/cycle, frame_count=100, no stalls.
//  4) Random m_axis_tready (50%) over 1000 beats -> output sequence bit-identical to scoreboard model,
//     output stable while stalled.
//  5) Non-last beat keep=64'h00FF, then last beat -> err_count=1, beat forwarded unmodified.
//  6) Assert rst_n=0 mid-frame with skid full -> m_axis_tvalid=0 immediately, counters 0;
//     next frame is handled as starting in ST_FIRST.

Source files
------------

// File: rtl/gpc_axis_tx_pad_if.sv
// AXI-Stream link bundle used on both sides of the CMAC TX pad stage.
interface gpc_axis_tx_pad_if #(
   parameter int unsigned DATA_W = 512,
   parameter int unsigned KEEP_W = DATA_W / 8
);
   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/gpc_axis_tx_pad.sv
// CMAC TX front end: pads short single-beat frames to the Ethernet minimum, flags illegal tkeep,
// and decouples both stream sides through an output register plus one skid entry.
module gpc_axis_tx_pad #(
   parameter int unsigned AXIS_DATA_WIDTH = 512,
   parameter int unsigned AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
   parameter int unsigned MIN_FRAME_BYTES = 60,
   parameter int unsigned CNT_WIDTH       = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   gpc_axis_tx_pad_if.slave     s_axis,
   gpc_axis_tx_pad_if.master    m_axis,
   output logic [CNT_WIDTH-1:0] frame_count,
   output logic [CNT_WIDTH-1:0] pad_count,
   output logic [CNT_WIDTH-1:0] err_count
);

   localparam logic [AXIS_KEEP_WIDTH-1:0] MinMask =
      {AXIS_KEEP_WIDTH{1'b1}} >> (AXIS_KEEP_WIDTH - MIN_FRAME_BYTES);

   typedef enum logic [0:0] {StFirst, StMid} state_t;

   state_t                     state;
   logic                       in_ready;
   logic                       out_valid;
   logic                       out_last;
   logic [AXIS_DATA_WIDTH-1:0] out_data;
   logic [AXIS_KEEP_WIDTH-1:0] out_keep;
   logic                       skid_valid;
   logic                       skid_last;
   logic [AXIS_DATA_WIDTH-1:0] skid_data;
   logic [AXIS_KEEP_WIDTH-1:0] skid_keep;

   logic                       in_hs;
   logic                       out_free;
   logic                       out_hs;
   logic                       pad_hit;
   logic                       err_hit;
   logic                       skid_valid_nxt;
   int unsigned                pop;
   logic [AXIS_DATA_WIDTH-1:0] proc_data;
   logic [AXIS_KEEP_WIDTH-1:0] proc_keep;

   assign s_axis.tready = in_ready;
   assign m_axis.tvalid = out_valid;
   assign m_axis.tdata  = out_data;
   assign m_axis.tkeep  = out_keep;
   assign m_axis.tlast  = out_last;

   always_comb begin
      in_hs    = s_axis.tvalid && in_ready;
      out_free = m_axis.tready || !out_valid;
      out_hs   = out_valid && m_axis.tready;

      pop = 0;
      for (int i = 0; i < int'(AXIS_KEEP_WIDTH); i++) begin
         if (s_axis.tkeep[i]) pop++;
      end

      pad_hit = (state == StFirst) && s_axis.tlast && (pop < MIN_FRAME_BYTES);
      err_hit = (s_axis.tkeep == '0) || (!s_axis.tlast && (s_axis.tkeep != '1));

      proc_data = s_axis.tdata;
      proc_keep = s_axis.tkeep;
      if (pad_hit) begin
         proc_keep = s_axis.tkeep | MinMask;
         for (int i = 0; i < int'(AXIS_KEEP_WIDTH); i++) begin
            if (!s_axis.tkeep[i] && MinMask[i]) proc_data[8*i +: 8] = 8'h00;
         end
      end

      // Skid fills only when the output register is blocked; it drains before any new input.
      skid_valid_nxt = (!out_free && in_hs) || (skid_valid && !out_free);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= StFirst;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         out_data    <= '0;
         out_keep    <= '0;
         skid_valid  <= 1'b0;
         skid_last   <= 1'b0;
         skid_data   <= '0;
         skid_keep   <= '0;
         frame_count <= '0;
         pad_count   <= '0;
         err_count   <= '0;
      end else begin
         skid_valid <= skid_valid_nxt;
         in_ready   <= !skid_valid_nxt;

         if (out_free) begin
            if (skid_valid) begin
               out_valid <= 1'b1;
               out_data  <= skid_data;
               out_keep  <= skid_keep;
               out_last  <= skid_last;
            end else if (in_hs) begin
               out_valid <= 1'b1;
               out_data  <= proc_data;
               out_keep  <= proc_keep;
               out_last  <= s_axis.tlast;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (in_hs) begin
            skid_data <= proc_data;
            skid_keep <= proc_keep;
            skid_last <= s_axis.tlast;
         end

         if (in_hs) state <= s_axis.tlast ? StFirst : StMid;

         if (out_hs && out_last && (frame_count != '1)) frame_count <= frame_count + CNT_WIDTH'(1);
         if (in_hs && pad_hit && (pad_count != '1)) pad_count <= pad_count + CNT_WIDTH'(1);
         if (in_hs && err_hit && (err_count != '1)) err_count <= err_count + CNT_WIDTH'(1);
      end
   end

endmodule
